// File: rtl/multi_issue_decoder.sv
// Multi-lane instruction decoder with registered outputs, a one-entry replay
// buffer for bundles accepted under stall, and a saturating stall counter.
//   state | meaning
//   RUN   | accepting bundles; outputs carry last decoded bundle or a bubble
//   HOLD  | replay buffer holds a bundle accepted while stalled
module multi_issue_decoder #(
    parameter int LANES = 2,
    parameter int IW    = 16,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*IW-1:0]   instr,
    input  logic [LANES-1:0]      lane_valid,
    input  logic                  stall,
    input  logic                  branch_taken,
    output logic                  out_valid,
    output logic [LANES*16-1:0]   ctrl,
    output logic [LANES-1:0]      out_lane_valid,
    output logic [LANES*IW-1:0]   out_instr,
    output logic [CNT_W-1:0]      stall_cnt
);

    typedef enum logic {RUN, HOLD} state_t;

    state_t                state, state_nxt;
    logic [LANES*IW-1:0]   buf_instr, buf_instr_nxt;
    logic [LANES-1:0]      buf_mask, buf_mask_nxt;
    logic                  emit;
    logic [LANES*IW-1:0]   src_instr;
    logic [LANES-1:0]      src_mask;
    logic [LANES*16-1:0]   ctrl_nxt;
    logic [LANES-1:0]      lane_nxt;
    logic [LANES*IW-1:0]   instr_nxt;

    function automatic logic [15:0] decode_op(input logic [3:0] op);
        logic [15:0] v;
        v = '0;
        case (op)
            4'd1:  begin v[0]  = 1'b1; v[15] = 1'b1; end
            4'd2:  begin v[1]  = 1'b1; v[15] = 1'b1; end
            4'd3:  begin v[2]  = 1'b1; v[15] = 1'b1; end
            4'd4:  begin v[3]  = 1'b1; v[15] = 1'b1; end
            4'd5:  v[4] = 1'b1;
            4'd6:  v[5] = 1'b1;
            4'd7:  begin v[6]  = 1'b1; v[15] = 1'b1; end
            4'd8:  begin v[7]  = 1'b1; v[15] = 1'b1; end
            4'd9:  begin v[8]  = 1'b1; v[15] = 1'b1; end
            4'd10: begin v[9]  = 1'b1; v[15] = 1'b1; end
            4'd11: begin v[10] = 1'b1; v[15] = 1'b1; end
            4'd12: v[14] = 1'b1;
            4'd13: begin v[11] = 1'b1; v[15] = 1'b1; end
            4'd14: v[12] = 1'b1;
            4'd15: v[13] = 1'b1;
            default: v = '0;
        endcase
        return v;
    endfunction

    assign in_ready = (state == RUN);

    // Flush wins over everything, including a bundle presented this cycle.
    always_comb begin
        state_nxt     = state;
        buf_instr_nxt = buf_instr;
        buf_mask_nxt  = buf_mask;
        emit          = 1'b0;
        src_instr     = instr;
        src_mask      = lane_valid;
        if (branch_taken) begin
            state_nxt     = RUN;
            buf_instr_nxt = '0;
            buf_mask_nxt  = '0;
        end else if (state == RUN) begin
            if (in_valid) begin
                if (stall) begin
                    buf_instr_nxt = instr;
                    buf_mask_nxt  = lane_valid;
                    state_nxt     = HOLD;
                end else begin
                    emit = 1'b1;
                end
            end
        end else if (!stall) begin
            emit          = 1'b1;
            src_instr     = buf_instr;
            src_mask      = buf_mask;
            buf_instr_nxt = '0;
            buf_mask_nxt  = '0;
            state_nxt     = RUN;
        end
    end

    always_comb begin
        ctrl_nxt  = '0;
        lane_nxt  = '0;
        instr_nxt = '0;
        if (emit) begin
            for (int k = 0; k < LANES; k++) begin
                if (src_mask[k]) begin
                    ctrl_nxt[16*k +: 16] = decode_op(src_instr[k*IW+IW-4 +: 4]);
                    instr_nxt[k*IW +: IW] = src_instr[k*IW +: IW];
                    lane_nxt[k]           = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= RUN;
            buf_instr      <= '0;
            buf_mask       <= '0;
            out_valid      <= 1'b0;
            ctrl           <= '0;
            out_lane_valid <= '0;
            out_instr      <= '0;
        end else begin
            state          <= state_nxt;
            buf_instr      <= buf_instr_nxt;
            buf_mask       <= buf_mask_nxt;
            out_valid      <= emit;
            ctrl           <= ctrl_nxt;
            out_lane_valid <= lane_nxt;
            out_instr      <= instr_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (stall && !branch_taken && stall_cnt != {CNT_W{1'b1}}) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multi_issue_decoder.sv
// Bench for multi_issue_decoder: scoreboard of expected bundles popped by a
// monitor whenever out_valid rises, plus scenario tasks with inline checks.
module tb_multi_issue_decoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instr = '0;
    logic [1:0]  lane_valid = '0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;

    logic        in_ready, out_valid;
    logic [31:0] ctrl, out_instr;
    logic [1:0]  out_lane_valid;
    logic [15:0] stall_cnt;

    logic        s_in_ready, s_out_valid;
    logic [31:0] s_ctrl, s_out_instr;
    logic [1:0]  s_out_lane_valid;
    logic [3:0]  s_stall_cnt;

    typedef struct {
        logic [31:0] ctrl;
        logic [1:0]  mask;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_cnt = '0;
    logic [3:0]  exp_cnt_s = '0;

    always #5 clk = ~clk;

    multi_issue_decoder #(.LANES(2), .IW(16), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .lane_valid(lane_valid), .stall(stall),
        .branch_taken(branch_taken), .out_valid(out_valid), .ctrl(ctrl),
        .out_lane_valid(out_lane_valid), .out_instr(out_instr), .stall_cnt(stall_cnt)
    );

    multi_issue_decoder #(.LANES(2), .IW(16), .CNT_W(4)) dut_s (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .instr(instr), .lane_valid(lane_valid), .stall(stall),
        .branch_taken(branch_taken), .out_valid(s_out_valid), .ctrl(s_ctrl),
        .out_lane_valid(s_out_lane_valid), .out_instr(s_out_instr), .stall_cnt(s_stall_cnt)
    );

    function automatic logic [15:0] ref_ctrl(input logic [15:0] w);
        case (w[15:12])
            4'd1:  return 16'h8001;
            4'd2:  return 16'h8002;
            4'd3:  return 16'h8004;
            4'd4:  return 16'h8008;
            4'd5:  return 16'h0010;
            4'd6:  return 16'h0020;
            4'd7:  return 16'h8040;
            4'd8:  return 16'h8080;
            4'd9:  return 16'h8100;
            4'd10: return 16'h8200;
            4'd11: return 16'h8400;
            4'd12: return 16'h4000;
            4'd13: return 16'h8800;
            4'd14: return 16'h1000;
            4'd15: return 16'h2000;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic push(input logic [31:0] ins, input logic [1:0] m);
        exp_t e;
        e.ctrl  = '0;
        e.mask  = m;
        e.instr = '0;
        for (int k = 0; k < 2; k++) begin
            if (m[k]) begin
                e.ctrl[16*k +: 16]  = ref_ctrl(ins[16*k +: 16]);
                e.instr[16*k +: 16] = ins[16*k +: 16];
            end
        end
        sb.push_back(e);
    endtask

    task automatic cycle();
        if (stall && !branch_taken) begin
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            if (exp_cnt_s != 4'hF) exp_cnt_s = exp_cnt_s + 4'd1;
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got ctrl=%h instr=%h, required no bundle", ctrl, out_instr);
                end else begin
                    mon_e = sb.pop_front();
                    if (ctrl !== mon_e.ctrl || out_lane_valid !== mon_e.mask || out_instr !== mon_e.instr) begin
                        errors++;
                        $display("FAIL bundle: got ctrl=%h mask=%b instr=%h, required ctrl=%h mask=%b instr=%h",
                                 ctrl, out_lane_valid, out_instr, mon_e.ctrl, mon_e.mask, mon_e.instr);
                    end
                end
            end else if (ctrl !== '0 || out_lane_valid !== '0 || out_instr !== '0) begin
                errors++;
                $display("FAIL bubble: got ctrl=%h mask=%b instr=%h, required all zero", ctrl, out_lane_valid, out_instr);
            end
        end
    end

    task automatic test_reset();
        #3;
        checks++;
        if (out_valid !== 1'b0 || ctrl !== '0 || stall_cnt !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got ov=%b ctrl=%h cnt=%0d rdy=%b, required 0 0 0 1", out_valid, ctrl, stall_cnt, in_ready);
        end
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        cycle();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== '0) begin
            errors++;
            $display("FAIL post_reset: got ov=%b rdy=%b cnt=%0d, required 0 1 0", out_valid, in_ready, stall_cnt);
        end
    endtask

    task automatic test_stall_replay();
        in_valid = 1'b1; instr = {16'hE000, 16'h3000}; lane_valid = 2'b11; stall = 1'b1;
        push(instr, lane_valid);
        cycle();
        instr = {16'h1111, 16'h2222};
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: got ov=%b rdy=%b, required 0 0", i + 2, out_valid, in_ready);
            end
            cycle();
        end
        checks++;
        if (out_valid !== 1'b0 || stall_cnt !== 16'd3) begin
            errors++;
            $display("FAIL hold_end: got ov=%b cnt=%0d, required 0 3", out_valid, stall_cnt);
        end
        stall = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_ready: got %b, required 0", in_ready);
        end
        cycle();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || ctrl !== 32'h1000_8004 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL replay: got ov=%b ctrl=%h rdy=%b, required 1 10008004 1", out_valid, ctrl, in_ready);
        end
        cycle();
    endtask

    task automatic test_basic();
        in_valid = 1'b1; instr = {16'h5123, 16'h1456}; lane_valid = 2'b11;
        push(instr, lane_valid);
        cycle();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || ctrl !== 32'h0010_8001) begin
            errors++;
            $display("FAIL basic: got ov=%b ctrl=%h, required 1 00108001", out_valid, ctrl);
        end
        cycle();
    endtask

    task automatic test_mask();
        in_valid = 1'b1; instr = {16'hC000, 16'h7000}; lane_valid = 2'b01;
        push(instr, lane_valid);
        cycle();
        in_valid = 1'b0;
        checks++;
        if (ctrl !== 32'h0000_8040 || out_lane_valid !== 2'b01 || out_instr !== 32'h0000_7000) begin
            errors++;
            $display("FAIL mask: got ctrl=%h mask=%b instr=%h, required 00008040 01 00007000", ctrl, out_lane_valid, out_instr);
        end
        cycle();
    endtask

    task automatic test_back_to_back();
        for (int op = 0; op < 16; op++) begin
            in_valid = 1'b1;
            instr = {4'(15 - op), 12'h5A5, 4'(op), 12'h3C3};
            lane_valid = 2'b11;
            push(instr, lane_valid);
            cycle();
        end
        for (int i = 0; i < 10; i++) begin
            instr = $urandom;
            lane_valid = 2'($urandom_range(0, 3));
            push(instr, lane_valid);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready: got %b, required 1", in_ready);
            end
            cycle();
        end
        in_valid = 1'b0;
        cycle(); cycle();
    endtask

    task automatic test_flush();
        in_valid = 1'b1; instr = {16'h1234, 16'h4321}; lane_valid = 2'b11; stall = 1'b1;
        cycle();
        in_valid = 1'b0; branch_taken = 1'b1;
        cycle();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_hold: got ov=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
        branch_taken = 1'b0; stall = 1'b0;
        cycle(); cycle(); cycle();
        in_valid = 1'b1; branch_taken = 1'b1; instr = {16'h2222, 16'h3333};
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_run_ready: got %b, required 1", in_ready);
        end
        cycle();
        in_valid = 1'b0; branch_taken = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || stall_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL flush_run: got ov=%b cnt=%0d, required 0 %0d", out_valid, stall_cnt, exp_cnt);
        end
        cycle(); cycle();
    endtask

    task automatic test_saturation();
        stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            checks++;
            if (s_stall_cnt !== exp_cnt_s || stall_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL sat_step%0d: got small=%0d big=%0d, required %0d %0d", i, s_stall_cnt, stall_cnt, exp_cnt_s, exp_cnt);
            end
        end
        checks++;
        if (s_stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_final: got %0d, required 15", s_stall_cnt);
        end
        stall = 1'b0;
        cycle();
    endtask

    task automatic test_reset_mid_hold();
        in_valid = 1'b1; instr = {16'h8000, 16'h9000}; lane_valid = 2'b11;
        push(instr, lane_valid);
        cycle();
        instr = {16'hB000, 16'hD000}; stall = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        #6;
        reset_n = 1'b0;
        #1;
        exp_cnt = '0; exp_cnt_s = '0;
        checks++;
        if (out_valid !== 1'b0 || ctrl !== '0 || stall_cnt !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_hold_reset: got ov=%b ctrl=%h cnt=%0d rdy=%b, required 0 0 0 1", out_valid, ctrl, stall_cnt, in_ready);
        end
        stall = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        cycle(); cycle(); cycle();
        in_valid = 1'b1; instr = {16'h4000, 16'hA000}; lane_valid = 2'b10;
        push(instr, lane_valid);
        cycle();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || ctrl !== 32'h8008_0000) begin
            errors++;
            $display("FAIL post_reset_bundle: got ov=%b ctrl=%h, required 1 80080000", out_valid, ctrl);
        end
        cycle(); cycle();
    endtask

    initial begin
        test_reset();
        test_stall_replay();
        test_basic();
        test_mask();
        test_back_to_back();
        test_flush();
        test_saturation();
        test_reset_mid_hold();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL pending_bundles: got %0d outstanding, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
